elevator_car: RTL
=================

# elevator_car

Per-car motion controller that sits directly downstream of the hall-call prioritizer. It accepts an assigned target floor for one car, holds all pending targets in a 16-bit mask, and moves the car floor by floor with a SCAN (keep-direction) policy, opening the door at each pending floor. Its `state` output is the 6-bit `{floor, dir}` word that the prioritizer consumes for this car. Three instances make up the car bank.

## Interface
Parameters:
- `FLOORS`, 16: number of floors; valid targets are 0..FLOORS-1, with FLOORS ≤ 16.
- `TRAVEL_CYCLES`, 8: clock cycles per one-floor move.
- `DOOR_CYCLES`, 4: clock cycles the door stays open.

Ports:
- `clock`  in  1: single clock; rising edge.
- `reset`  in  1: asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `assign`  in  1: one-cycle pulse; the prioritizer selected this car for `obj`.
- `obj`  in  4: target floor, sampled when `assign`=1.
- `state`  out  6: `{floor[3:0], dir[1:0]}`. `dir` encoding: 2'b11 = up, 2'b01 = down, 2'b00 = idle.
- `door_open`  out  1: door open.
- `pending`  out  16: registered target mask; bit n means a stop is requested at floor n.
- `busy`  out  1: 1 whenever the FSM is not in IDLE.

## Operation
- Reset values: floor=0, dir=00, door_open=0, pending=0, busy=0, FSM=IDLE, counters=0.
- Handling `assign`:
  - `obj` ≥ FLOORS: ignored.
  - In DOOR with `obj`==floor: the door counter restarts and no pending bit is set.
  - Otherwise: `pending[obj]` is set on the next edge.
- FSM states are IDLE, MOVE and DOOR.
- IDLE:
  - `pending[floor]`=1 → DOOR and clear that bit.
  - Otherwise, `pending`≠0 → MOVE toward the nearest pending floor. On a distance tie, choose up.
  - Set `dir` in the same edge.
- MOVE:
  - The travel counter counts 0..TRAVEL_CYCLES-1.
  - On the terminal count, floor changes by ±1 according to `dir` and the counter clears.
  - If `pending[new floor]`=1 → DOOR on the same edge: `door_open`=1 and the bit is cleared.
- DOOR:
  - The door counter counts 0..DOOR_CYCLES-1.
  - On the terminal count, `door_open`=0. Then:
    - Pending above (up) or below (down) in the current `dir` → MOVE, same `dir`.
    - Else, pending in the opposite direction → MOVE with `dir` reversed.
    - Else → IDLE with `dir`=00.
- SCAN rule: `dir` never reverses while a pending bit lies strictly ahead of the car.
- Direction bounds: floor never goes below 0 or above FLOORS-1. The policy guarantees this; out-of-range movement is a design error (assertion).
- `assign` for the floor being departed (MOVE, counter>0) sets the pending bit. It is served on the return pass.
- Arithmetic: floor is 4-bit unsigned; "ahead" tests use mask compares (bits above/below floor), not subtraction.

## Timing
- `assign` → `pending` bit visible: 1 cycle.
- From IDLE with a new target on another floor:
  - `pending` set at edge 1.
  - MOVE and `dir` valid at edge 2.
  - First floor change at edge 2+TRAVEL_CYCLES.
- Each subsequent floor takes TRAVEL_CYCLES cycles.
- `door_open` rises on the same edge that floor reaches a pending stop, and stays high exactly DOOR_CYCLES cycles unless restarted.
- Simultaneous `assign` of the arrival floor and arrival edge: the bit is cleared (arrival wins) and the door opens. No duplicate stop.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). Pending targets are lost.

## Configuration
- Macro `ELEVATOR_CAR_DOOR_HOLD_EN`.
- Defined: adds input `door_hold` (1 bit). While `door_hold`=1 in DOOR, the door counter is held at 0 and the door stays open. Counting resumes on release.
- Undefined: no `door_hold` port. The door time is always DOOR_CYCLES (plus restarts).

## Test plan
Defaults for all scenarios: FLOORS=16, TRAVEL_CYCLES=8, DOOR_CYCLES=4.
- Reset check: assert `reset` → `state`=6'b0000_00, `door_open`=0, `pending`=16'h0000, `busy`=0.
- Single trip: from floor 0 idle, `assign` obj=3 → `pending`=16'h0008 at edge 1; `state`=6'b0000_11 at edge 2; floor=1/2/3 at edges 10/18/26; `door_open` high edges 26–29; `state`=6'b0011_00 and `pending`=0 at edge 30.
- SCAN order: car moving up at floor 2 toward 5; `assign` obj=1 → stops at 5 first, then `dir`=01; the door opens at floor 1; it never stops at 1 before 5.
- Same-floor requests:
  - Idle at floor 4, `assign` obj=4 → `door_open`=1 next edge for 4 cycles; `pending` stays 0.
  - Repeat `assign` obj=4 on the 3rd door cycle → the door stays open 4 more cycles.
- Reset mid-move: assert `reset` while floor=2 and MOVE toward 7 with `pending`=16'h0080 → `state`=0, `pending`=0 immediately; idle after release.
- Illegal target and door hold:
  - `assign` obj=15 with FLOORS=12 → ignored; `pending` unchanged.
  - With `ELEVATOR_CAR_DOOR_HOLD_EN`: hold `door_hold`=1 for 10 cycles in DOOR → door open 10+4 cycles.

Source files
------------

// File: rtl/elevator_car.sv
// elevator_car: per-car SCAN motion controller. Holds pending stops in a
// 16-bit mask, moves one floor per TRAVEL_CYCLES and opens the door for
// DOOR_CYCLES at each requested floor.
// Optional feature: define ELEVATOR_CAR_DOOR_HOLD_EN to add door_hold_i,
// which freezes the door timer while asserted.
module elevator_car #(
  parameter int FLOORS        = 16,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        assign_i,
  input  logic [3:0]  obj_i,
`ifdef ELEVATOR_CAR_DOOR_HOLD_EN
  input  logic        door_hold_i,
`endif
  output logic [5:0]  state_o,
  output logic        door_open_o,
  output logic [15:0] pending_o,
  output logic        busy_o
);

  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DOOR_CYCLES - 1);
  localparam logic [4:0]    FLOORS_W = 5'(FLOORS);

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_DN   = 2'b01;
  localparam logic [1:0] DIR_UP   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} fsm_e;

  fsm_e          fsm_q, fsm_d;
  logic [3:0]    floor_q, floor_d;
  logic [1:0]    dir_q, dir_d;
  logic          door_q, door_d;
  logic [15:0]   pending_q, pending_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  logic          obj_ok, obj_here, hold;
  logic [15:0]   above_m, below_m;
  logic          near_found, near_up;

  assign obj_ok   = assign_i && ({1'b0, obj_i} < FLOORS_W);
  assign obj_here = obj_ok && (obj_i == floor_q);

`ifdef ELEVATOR_CAR_DOOR_HOLD_EN
  assign hold = door_hold_i;
`else
  assign hold = 1'b0;
`endif

  // Floor-relative masks and nearest-pending search (distance tie goes up).
  always_comb begin
    above_m    = '0;
    below_m    = '0;
    near_found = 1'b0;
    near_up    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      above_m[i] = (4'(i) > floor_q);
      below_m[i] = (4'(i) < floor_q);
    end
    for (int d = 1; d < 16; d++) begin
      if (!near_found) begin
        if ((int'(floor_q) + d < 16) && pending_q[4'(int'(floor_q) + d)]) begin
          near_found = 1'b1;
          near_up    = 1'b1;
        end else if ((int'(floor_q) - d >= 0) && pending_q[4'(int'(floor_q) - d)]) begin
          near_found = 1'b1;
          near_up    = 1'b0;
        end
      end
    end
  end

  // Next-state logic: request capture, then IDLE/MOVE/DOOR transitions.
  always_comb begin
    logic ahead, behind;
    fsm_d     = fsm_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    door_d    = door_q;
    tcnt_d    = tcnt_q;
    dcnt_d    = dcnt_q;
    pending_d = pending_q;
    ahead     = 1'b0;
    behind    = 1'b0;

    // A request for the current floor while idle or with the door open is
    // served by the door itself, never by a pending bit.
    if (obj_ok && !(obj_here && fsm_q != S_MOVE))
      pending_d[obj_i] = 1'b1;

    case (fsm_q)
      S_IDLE: begin
        if (obj_here) begin
          fsm_d  = S_DOOR;
          door_d = 1'b1;
          dcnt_d = '0;
        end else if (pending_q[floor_q]) begin
          fsm_d              = S_DOOR;
          door_d             = 1'b1;
          dcnt_d             = '0;
          pending_d[floor_q] = 1'b0;
        end else if (near_found) begin
          fsm_d  = S_MOVE;
          tcnt_d = '0;
          dir_d  = near_up ? DIR_UP : DIR_DN;
        end
      end

      S_MOVE: begin
        if (tcnt_q == T_LAST) begin
          tcnt_d  = '0;
          floor_d = (dir_q == DIR_UP) ? floor_q + 4'd1 : floor_q - 4'd1;
          // Arrival wins over a same-edge request for this floor.
          if (pending_d[floor_d]) begin
            fsm_d              = S_DOOR;
            door_d             = 1'b1;
            dcnt_d             = '0;
            pending_d[floor_d] = 1'b0;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      S_DOOR: begin
        if (obj_here || hold) begin
          dcnt_d = '0;
        end else if (dcnt_q == D_LAST) begin
          door_d = 1'b0;
          dcnt_d = '0;
          if (dir_q == DIR_UP) begin
            ahead  = |(pending_d & above_m);
            behind = |(pending_d & below_m);
          end else if (dir_q == DIR_DN) begin
            ahead  = |(pending_d & below_m);
            behind = |(pending_d & above_m);
          end
          if (ahead) begin
            fsm_d  = S_MOVE;
            tcnt_d = '0;
          end else if (behind) begin
            fsm_d  = S_MOVE;
            tcnt_d = '0;
            dir_d  = (dir_q == DIR_UP) ? DIR_DN : DIR_UP;
          end else begin
            fsm_d = S_IDLE;
            dir_d = DIR_IDLE;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end

      default: begin
        fsm_d = S_IDLE;
        dir_d = DIR_IDLE;
      end
    endcase
  end

  // State register; reset discards all pending targets.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q     <= S_IDLE;
      floor_q   <= '0;
      dir_q     <= DIR_IDLE;
      door_q    <= 1'b0;
      pending_q <= '0;
      tcnt_q    <= '0;
      dcnt_q    <= '0;
    end else begin
      fsm_q     <= fsm_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      door_q    <= door_d;
      pending_q <= pending_d;
      tcnt_q    <= tcnt_d;
      dcnt_q    <= dcnt_d;
    end
  end

  assign state_o     = {floor_q, dir_q};
  assign door_open_o = door_q;
  assign pending_o   = pending_q;
  assign busy_o      = (fsm_q != S_IDLE);

`ifndef SYNTHESIS
  // The SCAN policy must never drive the car past either end of the shaft.
  a_floor_range: assert property (@(posedge clock_i) disable iff (reset_i)
    int'(floor_q) < FLOORS);
  a_no_overrun: assert property (@(posedge clock_i) disable iff (reset_i)
    !(fsm_q == S_MOVE && tcnt_q == T_LAST &&
      ((dir_q == DIR_UP && int'(floor_q) == FLOORS - 1) ||
       (dir_q == DIR_DN && floor_q == 4'd0) || dir_q == DIR_IDLE)));
`endif

endmodule
